jtpopeye_cabinet: RTL and testbench

//  Cabinet input controller for the main CPU board. Debounces and synchronises NP joysticks,

---
 rtl/jtpopeye_cabinet_pkg.sv | 32 +++
 rtl/jtpopeye_cabinet_debounce.sv | 40 ++++
 rtl/jtpopeye_cabinet.sv | 138 +++++++++++++
 tb/tb_jtpopeye_cabinet.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtpopeye_cabinet_pkg.sv
// jtpopeye_cabinet_pkg: shared port map, field positions and limits for the cabinet inputs.
// Port indices of the Z80 input space, bit positions inside the system and player
// ports, the NP/NCOIN ceilings and the player-port formatter used by the read mux.
package jtpopeye_cabinet_pkg;
    localparam int MAX_NP    = 4;
    localparam int MAX_NCOIN = 2;
    localparam logic [2:0] PORT_AY     = 3'd0;
    localparam logic [2:0] PORT_SYS    = 3'd1;
    localparam logic [2:0] PORT_P_BASE = 3'd2;
    localparam int SYS_COIN0   = 7;
    localparam int SYS_SERVICE = 6;
    localparam int SYS_COIN1   = 5;
    localparam int SYS_START1  = 3;
    localparam int SYS_START0  = 2;
    localparam int SYS_START3  = 1;
    localparam int SYS_START2  = 0;
    localparam int JOY_L     = 0;
    localparam int JOY_R     = 1;
    localparam int JOY_DOWN  = 2;
    localparam int JOY_UP    = 3;
    localparam int JOY_PUNCH = 4;
    localparam int JOY_BTN2  = 5;
    typedef struct packed {
        logic       lvl;
        logic [2:0] fcnt;
        logic [1:0] pend;
    } coin_slot_t;
    // Player port swaps up/down relative to the joystick wiring.
    function automatic logic [7:0] player_port(input logic [5:0] j);
        return {2'b11, j[JOY_BTN2], j[JOY_PUNCH], j[JOY_DOWN], j[JOY_UP], j[JOY_R], j[JOY_L]};
    endfunction
endpackage

// File: rtl/jtpopeye_cabinet_debounce.sv
// jtpopeye_cabinet_debounce: 2-FF synchroniser plus per-bit debounce for a W-bit group.
// Ports: clk, rst_n (async, active-low), cen (debounce tick), din (raw, active-low),
//        dout (debounced state, resets to all ones).
module jtpopeye_cabinet_debounce #(
    parameter int W    = 1,
    parameter int DEBW = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cen,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    // The tick being evaluated is the (cnt+1)-th differing one, so committing at
    // cnt == 2**DEBW-2 requires exactly 2**DEBW-1 consecutive differing ticks.
    localparam logic [DEBW-1:0] LAST = {{(DEBW-1){1'b1}}, 1'b0};
    logic [W-1:0]    r_s1, r_s2, r_stable;
    logic [DEBW-1:0] r_cnt [W];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1     <= '1;
            r_s2     <= '1;
            r_stable <= '1;
            for (int i = 0; i < W; i++) r_cnt[i] <= '0;
        end else begin
            r_s1 <= din;
            r_s2 <= r_s1;
            if (cen) begin
                for (int i = 0; i < W; i++) begin
                    if (r_s2[i] == r_stable[i]) r_cnt[i] <= '0;
                    else if (r_cnt[i] == LAST) begin
                        r_stable[i] <= r_s2[i];
                        r_cnt[i]    <= '0;
                    end else r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end
    assign dout = r_stable;
endmodule

// File: rtl/jtpopeye_cabinet.sv
// jtpopeye_cabinet: cabinet input controller serving joysticks, starts, coins and service
// as active-low Z80 input ports.
// Ports: clk, rst_n (async, active-low), cen (cpu clock enable), LVBL (low in vblank),
//        joystick[7*NP], start_button[NP], coin_input[NCOIN], service (all active-low raw),
//        iorq_n/rd_n/addr (Z80 read), dout/in_cs (port data and mux select),
//        coin_cnt (meter pulse per accepted coin).
module jtpopeye_cabinet
    import jtpopeye_cabinet_pkg::*;
#(
    parameter int NP          = 2,
    parameter int NCOIN       = 1,
    parameter int DEBW        = 4,
    parameter int COIN_FRAMES = 3,
    parameter int FRAME_LATCH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen,
    input  logic              LVBL,
    input  logic [7*NP-1:0]   joystick,
    input  logic [NP-1:0]     start_button,
    input  logic [NCOIN-1:0]  coin_input,
    input  logic              service,
    input  logic              iorq_n,
    input  logic              rd_n,
    input  logic [2:0]        addr,
    output logic [7:0]        dout,
    output logic              in_cs,
    output logic [NCOIN-1:0]  coin_cnt
);
    localparam logic [2:0] CF = 3'(COIN_FRAMES);
    logic [7*NP-1:0]  w_joy_db, r_joy, w_joy;
    logic [NP-1:0]    w_start_db, r_start, w_start;
    logic [NCOIN-1:0] w_coin_db, r_coin_d, w_press, w_coin_lvl, r_coin_cnt;
    logic             w_service_db, r_lvbl_d, w_vbs, w_rd;
    logic [MAX_NP-1:0]    w_st4;
    logic [MAX_NCOIN-1:0] w_c2;
    logic [7:0]           w_sys;
    logic [NP-1:0]        w_unused_b6;
    coin_slot_t           r_slot [NCOIN];

    jtpopeye_cabinet_debounce #(.W(7*NP), .DEBW(DEBW)) u_db_joy (
        .clk(clk), .rst_n(rst_n), .cen(cen), .din(joystick), .dout(w_joy_db));
    jtpopeye_cabinet_debounce #(.W(NP), .DEBW(DEBW)) u_db_start (
        .clk(clk), .rst_n(rst_n), .cen(cen), .din(start_button), .dout(w_start_db));
    jtpopeye_cabinet_debounce #(.W(NCOIN), .DEBW(DEBW)) u_db_coin (
        .clk(clk), .rst_n(rst_n), .cen(cen), .din(coin_input), .dout(w_coin_db));
    jtpopeye_cabinet_debounce #(.W(1), .DEBW(DEBW)) u_db_service (
        .clk(clk), .rst_n(rst_n), .cen(cen), .din(service), .dout(w_service_db));

    assign w_vbs   = r_lvbl_d & ~LVBL;
    assign w_press = r_coin_d & ~w_coin_db;
    assign w_joy   = FRAME_LATCH != 0 ? r_joy : w_joy_db;
    assign w_start = FRAME_LATCH != 0 ? r_start : w_start_db;
    assign coin_cnt = r_coin_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lvbl_d <= 1'b1;
            r_joy    <= '1;
            r_start  <= '1;
        end else begin
            r_lvbl_d <= LVBL;
            if (w_vbs) begin
                r_joy   <= w_joy_db;
                r_start <= w_start_db;
            end
        end
    end

    // Coin stretch: a press edge takes priority over a coincident vblank start.
    // A slot always spends one full released frame before a pending coin re-asserts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_coin_d   <= '1;
            r_coin_cnt <= '0;
            for (int i = 0; i < NCOIN; i++) r_slot[i] <= '{lvl: 1'b1, fcnt: 3'd0, pend: 2'd0};
        end else begin
            r_coin_d <= w_coin_db;
            for (int i = 0; i < NCOIN; i++) begin
                if (w_press[i]) begin
                    r_coin_cnt[i] <= 1'b1;
                    if (r_slot[i].lvl) begin
                        r_slot[i].lvl  <= 1'b0;
                        r_slot[i].fcnt <= CF;
                    end else if (r_slot[i].pend != 2'd3) r_slot[i].pend <= r_slot[i].pend + 1'b1;
                end else begin
                    if (cen) r_coin_cnt[i] <= 1'b0;
                    if (w_vbs) begin
                        if (r_slot[i].fcnt != 3'd0) begin
                            r_slot[i].fcnt <= r_slot[i].fcnt - 1'b1;
                            if (r_slot[i].fcnt == 3'd1) r_slot[i].lvl <= 1'b1;
                        end else if (r_slot[i].lvl && r_slot[i].pend != 2'd0) begin
                            r_slot[i].pend <= r_slot[i].pend - 1'b1;
                            r_slot[i].lvl  <= 1'b0;
                            r_slot[i].fcnt <= CF;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCOIN; i++) w_coin_lvl[i] = r_slot[i].lvl;
    end

    always_comb begin
        w_st4 = '1;
        w_st4[NP-1:0] = w_start;
        w_c2 = '1;
        w_c2[NCOIN-1:0] = w_coin_lvl;
        w_sys = 8'hFF;
        w_sys[SYS_COIN0]   = w_c2[0];
        w_sys[SYS_SERVICE] = w_service_db;
        w_sys[SYS_COIN1]   = w_c2[1];
        w_sys[SYS_START1]  = w_st4[1];
        w_sys[SYS_START0]  = w_st4[0];
        w_sys[SYS_START3]  = w_st4[3];
        w_sys[SYS_START2]  = w_st4[2];
        // Port 0 belongs to the AY/DIP path and is never claimed here.
        w_rd  = !iorq_n && !rd_n && addr != PORT_AY;
        in_cs = 1'b0;
        dout  = 8'hFF;
        if (w_rd && addr == PORT_SYS) begin
            in_cs = 1'b1;
            dout  = w_sys;
        end
        // Player p sits at 1+NP-p, so the last player lands on PORT_P_BASE.
        for (int p = 0; p < NP; p++) begin
            w_unused_b6[p] = w_joy[7*p+6];
            if (w_rd && addr == 3'(int'(PORT_P_BASE) + NP - 1 - p)) begin
                in_cs = 1'b1;
                dout  = player_port(w_joy[7*p +: 6]);
            end
        end
    end
endmodule

// File: tb/tb_jtpopeye_cabinet.sv
// tb_jtpopeye_cabinet: directed bench for the cabinet input controller (latched and transparent builds).
module tb_jtpopeye_cabinet;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        LVBL = 1'b1;
    logic [13:0] joystick = '1;
    logic [1:0]  start_button = '1;
    logic [0:0]  coin_input = '1;
    logic        service = 1'b1;
    logic        iorq_n = 1'b1;
    logic        rd_n = 1'b1;
    logic [2:0]  addr = '0;
    logic        cen;
    logic [7:0]  dout, dout_t;
    logic        in_cs, in_cs_t;
    logic [0:0]  coin_cnt, coin_cnt_t;
    logic [1:0]  r_div = '0;
    logic        r_cc_d = 1'b0;
    int          n_pulse = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) r_div <= r_div + 1'b1;
    assign cen = (r_div == 2'd3);

    always @(posedge clk) begin
        r_cc_d <= coin_cnt[0];
        if (coin_cnt[0] && !r_cc_d) n_pulse <= n_pulse + 1;
    end

    jtpopeye_cabinet #(.NP(2), .NCOIN(1), .DEBW(4), .COIN_FRAMES(3), .FRAME_LATCH(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .LVBL(LVBL), .joystick(joystick),
        .start_button(start_button), .coin_input(coin_input), .service(service),
        .iorq_n(iorq_n), .rd_n(rd_n), .addr(addr), .dout(dout), .in_cs(in_cs),
        .coin_cnt(coin_cnt));

    jtpopeye_cabinet #(.NP(2), .NCOIN(1), .DEBW(4), .COIN_FRAMES(3), .FRAME_LATCH(0)) u_dut_t (
        .clk(clk), .rst_n(rst_n), .cen(cen), .LVBL(LVBL), .joystick(joystick),
        .start_button(start_button), .coin_input(coin_input), .service(service),
        .iorq_n(iorq_n), .rd_n(rd_n), .addr(addr), .dout(dout_t), .in_cs(in_cs_t),
        .coin_cnt(coin_cnt_t));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cen_ticks(input int n);
        repeat (n) begin
            do @(negedge clk); while (!cen);
            @(posedge clk);
        end
        #1;
    endtask

    task automatic vblank();
        @(posedge clk);
        #1 LVBL = 1'b0;
        repeat (3) @(posedge clk);
        #1 LVBL = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic rd_port(input logic [2:0] a, output logic [7:0] d, output logic c, output logic [7:0] dt);
        iorq_n = 1'b0;
        rd_n = 1'b0;
        addr = a;
        #1;
        d = dout;
        c = in_cs;
        dt = dout_t;
        iorq_n = 1'b1;
        rd_n = 1'b1;
        #1;
    endtask

    task automatic coin_press();
        coin_input = 1'b0;
        cen_ticks(20);
        coin_input = 1'b1;
        cen_ticks(20);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  d, dt;
        logic        c;
        int          p0;
        logic [11:0] pat;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int a = 0; a < 8; a++) begin
            rd_port(3'(a), d, c, dt);
            check($sformatf("rst_dout_a%0d", a), d, 8'hFF);
            check($sformatf("rst_cs_a%0d", a), c, (a >= 1 && a <= 3) ? 1 : 0);
        end
        addr = 3'd1;
        #1;
        check("nostrobe_dout", dout, 8'hFF);
        check("nostrobe_cs", in_cs, 0);
        check("rst_coin_cnt", coin_cnt, 0);

        cen_ticks(1);
        joystick[4] = 1'b0;
        cen_ticks(14);
        joystick[4] = 1'b1;
        cen_ticks(3);
        vblank();
        rd_port(3'd3, d, c, dt);
        check("glitch14_fl", d, 8'hFF);
        check("glitch14_tr", dt, 8'hFF);
        joystick[4] = 1'b0;
        cen_ticks(15);
        joystick[4] = 1'b1;
        rd_port(3'd3, d, c, dt);
        check("punch15_prevbl_fl", d, 8'hFF);
        check("punch15_tr", dt, 8'hEF);
        vblank();
        rd_port(3'd3, d, c, dt);
        check("punch15_fl", d, 8'hEF);
        cen_ticks(20);
        vblank();
        rd_port(3'd3, d, c, dt);
        check("punch_release", d, 8'hFF);

        joystick[3] = 1'b0;
        joystick[5] = 1'b0;
        cen_ticks(16);
        rd_port(3'd3, d, c, dt);
        check("up_btn2_tr", dt, 8'hDB);
        vblank();
        rd_port(3'd3, d, c, dt);
        check("up_btn2_fl", d, 8'hDB);
        joystick[3] = 1'b1;
        joystick[5] = 1'b1;
        joystick[2] = 1'b0;
        cen_ticks(16);
        vblank();
        rd_port(3'd3, d, c, dt);
        check("down_fl", d, 8'hF7);
        joystick[2] = 1'b1;
        cen_ticks(16);
        vblank();

        joystick[8] = 1'b0;
        cen_ticks(10);
        rd_port(3'd2, d, c, dt);
        check("p2r_early_tr", dt, 8'hFF);
        cen_ticks(6);
        rd_port(3'd2, d, c, dt);
        check("p2r_midframe_fl", d, 8'hFF);
        check("p2r_tr", dt, 8'hFD);
        vblank();
        rd_port(3'd2, d, c, dt);
        check("p2r_fl", d, 8'hFD);
        rd_port(3'd3, d, c, dt);
        check("p1_idle", d, 8'hFF);
        joystick[8] = 1'b1;
        cen_ticks(16);
        vblank();

        start_button[0] = 1'b0;
        service = 1'b0;
        cen_ticks(16);
        rd_port(3'd1, d, c, dt);
        check("service_unlatched", d, 8'hBF);
        check("start0_svc_tr", dt, 8'hBB);
        vblank();
        rd_port(3'd1, d, c, dt);
        check("start0_svc_fl", d, 8'hBB);
        start_button = 2'b01;
        service = 1'b1;
        cen_ticks(16);
        vblank();
        rd_port(3'd1, d, c, dt);
        check("start1_fl", d, 8'hF7);
        start_button = 2'b11;
        cen_ticks(16);
        vblank();

        p0 = n_pulse;
        coin_press();
        rd_port(3'd1, d, c, dt);
        check("coin_low", d, 8'h7F);
        check("coin_one_pulse", n_pulse, p0 + 1);
        for (int v = 1; v <= 3; v++) begin
            vblank();
            rd_port(3'd1, d, c, dt);
            check($sformatf("coin_stretch_vb%0d", v), d, v < 3 ? 8'h7F : 8'hFF);
        end

        p0 = n_pulse;
        repeat (3) coin_press();
        check("pend_pulses", n_pulse, p0 + 3);
        pat = 12'b1100_0100_0100;
        for (int v = 0; v < 12; v++) begin
            vblank();
            rd_port(3'd1, d, c, dt);
            check($sformatf("pend_vb%0d", v + 1), d[7], pat[v]);
        end

        repeat (3) coin_press();
        rd_port(3'd1, d, c, dt);
        check("pre_reset_coin", d, 8'h7F);
        p0 = n_pulse;
        #2 rst_n = 1'b0;
        rd_port(3'd1, d, c, dt);
        check("reset_immediate", d, 8'hFF);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int v = 0; v < 8; v++) begin
            vblank();
            rd_port(3'd1, d, c, dt);
            check($sformatf("reset_no_recoin_vb%0d", v + 1), d, 8'hFF);
        end
        check("reset_no_pulse", n_pulse, p0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
